// File: rtl/skid_pipe_reg_pkg.sv
// Shared types and ROB-age helpers for the skid pipeline register.
// Age is measured from the ROB head, so comparisons stay correct across index wrap-around.
package skid_pipe_reg_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ROB_ADDR_W_DEF = 4;
  localparam int AGE_MAX_W      = 16;

  typedef logic [ROB_ADDR_W_DEF-1:0] rob_addr_t;
  typedef logic [AGE_MAX_W-1:0]      age_word_t;

  // Inputs are zero-extended ROB indices; w is the real index width (1..AGE_MAX_W).
  function automatic logic rob_younger(input age_word_t a,
                                       input age_word_t ref_addr,
                                       input age_word_t head,
                                       input int        w);
    age_word_t mask;
    age_word_t age_a;
    age_word_t age_r;
    mask  = {AGE_MAX_W{1'b1}} >> (AGE_MAX_W - w);
    age_a = (a - head) & mask;
    age_r = (ref_addr - head) & mask;
    return age_a > age_r;
  endfunction

endpackage

// File: rtl/skid_pipe_reg_kill.sv
// Combinational squash decision for one ROB index: flush_all, or strictly younger than the
// mispredicted entry. The mispredicted entry itself survives.
module rob_age_kill
  import skid_pipe_reg_pkg::*;
#(
  parameter int ROB_ADDR_W = ROB_ADDR_W_DEF
) (
  input  logic [ROB_ADDR_W-1:0] addr,
  input  logic                  flush_all,
  input  logic                  flush_valid,
  input  logic [ROB_ADDR_W-1:0] flush_rob_addr,
  input  logic [ROB_ADDR_W-1:0] rob_head,
  output logic                  kill
);

  age_word_t addr_w;
  age_word_t flush_w;
  age_word_t head_w;

  assign addr_w  = age_word_t'(addr);
  assign flush_w = age_word_t'(flush_rob_addr);
  assign head_w  = age_word_t'(rob_head);

  assign kill = flush_all | (flush_valid & rob_younger(addr_w, flush_w, head_w, ROB_ADDR_W));

endmodule

// File: rtl/skid_pipe_reg.sv
// Payload-agnostic pipeline stage with valid/ready backpressure, optional 2-entry skid buffer
// and selective squash of entries younger than a mispredicted ROB entry.
module skid_pipe_reg
  import skid_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROB_ADDR_W = ROB_ADDR_W_DEF,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROB_ADDR_W-1:0] in_rob_addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROB_ADDR_W-1:0] out_rob_addr,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  flush_all,
  input  logic                  flush_valid,
  input  logic [ROB_ADDR_W-1:0] flush_rob_addr,
  input  logic [ROB_ADDR_W-1:0] rob_head,
  output logic [1:0]            occupancy
);

  logic                  main_v, skid_v;
  logic [ROB_ADDR_W-1:0] main_rob, skid_rob;
  logic [DATA_W-1:0]     main_data, skid_data;

  logic                  main_v_nx, skid_v_nx;
  logic [ROB_ADDR_W-1:0] main_rob_nx, skid_rob_nx;
  logic [DATA_W-1:0]     main_data_nx, skid_data_nx;

  logic kill_main, kill_skid, kill_in;
  logic in_fire, out_fire;

  rob_age_kill #(.ROB_ADDR_W(ROB_ADDR_W)) u_kill_main (
    .addr(main_rob), .flush_all(flush_all), .flush_valid(flush_valid),
    .flush_rob_addr(flush_rob_addr), .rob_head(rob_head), .kill(kill_main)
  );

  rob_age_kill #(.ROB_ADDR_W(ROB_ADDR_W)) u_kill_skid (
    .addr(skid_rob), .flush_all(flush_all), .flush_valid(flush_valid),
    .flush_rob_addr(flush_rob_addr), .rob_head(rob_head), .kill(kill_skid)
  );

  rob_age_kill #(.ROB_ADDR_W(ROB_ADDR_W)) u_kill_in (
    .addr(in_rob_addr), .flush_all(flush_all), .flush_valid(flush_valid),
    .flush_rob_addr(flush_rob_addr), .rob_head(rob_head), .kill(kill_in)
  );

  // Masking out_valid with the same-cycle kill keeps downstream from consuming a dead entry.
  assign out_valid    = main_v & ~kill_main;
  assign out_rob_addr = main_rob;
  assign out_data     = main_data;
  assign out_fire     = out_valid & out_ready;
  assign in_fire      = in_valid & in_ready & ~kill_in;
  assign occupancy    = {1'b0, main_v} + {1'b0, skid_v};

  generate
    if (SKID != 0) begin : g_skid
      logic main_s, skid_s;
      logic ready_q;

      always_comb begin
        main_s       = main_v & ~kill_main;
        skid_s       = skid_v & ~kill_skid;
        main_v_nx    = main_s;
        main_rob_nx  = main_rob;
        main_data_nx = main_data;
        skid_v_nx    = skid_s;
        skid_rob_nx  = skid_rob;
        skid_data_nx = skid_data;
        // A free MAIN slot is refilled from SKID first so the older entry stays at the head.
        if (!main_s || out_fire) begin
          if (skid_s) begin
            main_v_nx    = 1'b1;
            main_rob_nx  = skid_rob;
            main_data_nx = skid_data;
            skid_v_nx    = in_fire;
            if (in_fire) begin
              skid_rob_nx  = in_rob_addr;
              skid_data_nx = in_data;
            end
          end else begin
            main_v_nx = in_fire;
            skid_v_nx = 1'b0;
            if (in_fire) begin
              main_rob_nx  = in_rob_addr;
              main_data_nx = in_data;
            end
          end
        end else if (in_fire) begin
          skid_v_nx    = 1'b1;
          skid_rob_nx  = in_rob_addr;
          skid_data_nx = in_data;
        end
      end

      // in_ready is a pure flop so no combinational path from out_ready reaches upstream.
      always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b1;
        else     ready_q <= ~skid_v_nx;
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      assign in_ready = ~main_v | out_ready | kill_main;

      always_comb begin
        main_v_nx    = main_v;
        main_rob_nx  = main_rob;
        main_data_nx = main_data;
        skid_v_nx    = 1'b0;
        skid_rob_nx  = skid_rob;
        skid_data_nx = skid_data;
        if (in_fire) begin
          main_v_nx    = 1'b1;
          main_rob_nx  = in_rob_addr;
          main_data_nx = in_data;
        end else if (out_fire || kill_main) begin
          main_v_nx = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_rob  <= '0;
      skid_rob  <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      main_v    <= main_v_nx;
      skid_v    <= skid_v_nx;
      main_rob  <= main_rob_nx;
      skid_rob  <= skid_rob_nx;
      main_data <= main_data_nx;
      skid_data <= skid_data_nx;
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg: SKID=1 and SKID=0 instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_skid_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush_all, flush_valid;
  logic [3:0]  in_rob_addr, flush_rob_addr, rob_head;
  logic [31:0] in_data;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [3:0]  out_rob1, out_rob0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] data;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  skid_pipe_reg #(.DATA_W(32), .ROB_ADDR_W(4), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_rob_addr(in_rob_addr), .in_data(in_data), .out_valid(out_valid1),
    .out_ready(out_ready), .out_rob_addr(out_rob1), .out_data(out_data1),
    .flush_all(flush_all), .flush_valid(flush_valid), .flush_rob_addr(flush_rob_addr),
    .rob_head(rob_head), .occupancy(occ1)
  );

  skid_pipe_reg #(.DATA_W(32), .ROB_ADDR_W(4), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_rob_addr(in_rob_addr), .in_data(in_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_rob_addr(out_rob0), .out_data(out_data0),
    .flush_all(flush_all), .flush_valid(flush_valid), .flush_rob_addr(flush_rob_addr),
    .rob_head(rob_head), .occupancy(occ0)
  );

  // Age relative to the ROB head, computed with plain modular arithmetic.
  function automatic bit kill_f(input logic [3:0] x);
    int ax;
    int af;
    ax = (int'(x) - int'(rob_head) + 16) % 16;
    af = (int'(flush_rob_addr) - int'(rob_head) + 16) % 16;
    return flush_all || (flush_valid && (ax > af));
  endfunction

  function automatic bit exp_valid(input ent_t q[$]);
    if (q.size() == 0) return 1'b0;
    return !kill_f(q[0].rob);
  endfunction

  function automatic bit exp_ready(input ent_t q[$], input bit skid);
    if (skid) return q.size() < 2;
    if (q.size() == 0) return 1'b1;
    return out_ready || kill_f(q[0].rob);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = exp_valid(q1);
    check_output("skid.in_ready", 32'(in_ready1), 32'(exp_ready(q1, 1'b1)));
    check_output("skid.out_valid", 32'(out_valid1), 32'(ev));
    check_output("skid.occupancy", 32'(occ1), 32'(q1.size()));
    if (ev) begin
      check_output("skid.out_rob_addr", 32'(out_rob1), 32'(q1[0].rob));
      check_output("skid.out_data", out_data1, q1[0].data);
    end
    ev = exp_valid(q0);
    check_output("noskid.in_ready", 32'(in_ready0), 32'(exp_ready(q0, 1'b0)));
    check_output("noskid.out_valid", 32'(out_valid0), 32'(ev));
    check_output("noskid.occupancy", 32'(occ0), 32'(q0.size()));
    if (ev) begin
      check_output("noskid.out_rob_addr", 32'(out_rob0), 32'(q0[0].rob));
      check_output("noskid.out_data", out_data0, q0[0].data);
    end
  endtask

  // Survivors keep their order; the head leaves on out_fire and the new entry joins the tail.
  task automatic model_step(inout ent_t q[$], input bit skid);
    ent_t nq[$];
    ent_t e;
    bit   ir, ov, of, inf;
    ir  = exp_ready(q, skid);
    ov  = exp_valid(q);
    of  = ov && out_ready;
    inf = in_valid && ir && !kill_f(in_rob_addr);
    nq  = {};
    foreach (q[i]) if (!kill_f(q[i].rob)) nq.push_back(q[i]);
    if (of) void'(nq.pop_front());
    if (inf) begin
      e.rob  = in_rob_addr;
      e.data = in_data;
      nq.push_back(e);
    end
    if (rst) nq = {};
    q = nq;
  endtask

  task automatic apply_stimulus(input logic r, input logic iv, input logic [3:0] rob,
                                input logic [31:0] d, input logic ordy, input logic fa,
                                input logic fv, input logic [3:0] frob, input logic [3:0] head);
    @(negedge clk);
    rst            = r;
    in_valid       = iv;
    in_rob_addr    = rob;
    in_data        = d;
    out_ready      = ordy;
    flush_all      = fa;
    flush_valid    = fv;
    flush_rob_addr = frob;
    rob_head       = head;
    #1;
    if (!r) check_all();
    @(posedge clk);
    model_step(q1, 1'b1);
    model_step(q0, 1'b0);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush_all = 1'b0; flush_valid = 1'b0;
    in_rob_addr = '0; flush_rob_addr = '0; rob_head = '0; in_data = '0;

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single entry, one-cycle latency.
    apply_stimulus(0, 1, 3, 32'hA5, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Fill under backpressure, third push ignored, then drain in order.
    apply_stimulus(0, 1, 1, 32'h11, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 2, 32'h22, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 3, 32'h33, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Wrap-around squash: head 14, rob 15 survives, rob 0 dies.
    apply_stimulus(0, 1, 15, 32'h0F, 0, 0, 0, 0, 14);
    apply_stimulus(0, 1, 0, 32'h00, 0, 0, 0, 0, 14);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 15, 14);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 14);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 14);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 14);

    // Same-cycle squash of the head must not be consumed.
    apply_stimulus(0, 1, 6, 32'h66, 0, 0, 0, 0, 4);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 5, 4);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 4);

    // flush_all with a full stage and an incoming entry.
    apply_stimulus(0, 1, 1, 32'h71, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 2, 32'h72, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 3, 32'h73, 0, 1, 1, 9, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Streaming with out_ready high: one beat per cycle.
    for (int i = 0; i < 8; i++)
      apply_stimulus(0, 1, 4'(i), 32'h600 + 32'(i), 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Random traffic with occasional squashes and resets.
    for (int i = 0; i < 400; i++) begin
      logic r, fa, fv;
      r  = ($urandom_range(99) == 0);
      fa = ($urandom_range(29) == 0);
      fv = ($urandom_range(7) == 0);
      apply_stimulus(r, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom,
                     1'($urandom_range(2) != 0), fa, fv, 4'($urandom_range(15)),
                     4'($urandom_range(15)));
    end
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
